// File: rtl/mlcla_serial_add64_pkg.sv
// Shared definitions for the slice-serial 64-bit adder: FSM encoding and
// default geometry of the adder slices.
package mlcla_serial_add64_pkg;

  localparam int SLICE_W_DEF  = 16;
  localparam int N_SLICES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mlcla_serial_add64_mlcladder.sv
// Two-level carry-lookahead adder: 4-bit groups produce group generate and
// propagate terms, and the group carries are resolved from those terms.
module mlcladder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = (W + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] a_pad_s;
  logic [WP-1:0] b_pad_s;
  logic [WP-1:0] g_s;
  logic [WP-1:0] p_s;
  logic [NG-1:0] gg_s;
  logic [NG-1:0] gp_s;
  logic [NG:0]   gc_s;
  logic [WP-1:0] c_s;
  logic [WP-1:0] sum_pad_s;

  assign a_pad_s = WP'(a);
  assign b_pad_s = WP'(b);
  assign g_s     = a_pad_s & b_pad_s;
  assign p_s     = a_pad_s ^ b_pad_s;

  // Group generate/propagate, then lookahead over groups, then bit carries.
  always_comb begin
    gg_s      = '0;
    gp_s      = '0;
    gc_s      = '0;
    c_s       = '0;
    sum_pad_s = '0;
    for (int j = 0; j < NG; j++) begin
      gg_s[j] = 1'b0;
      gp_s[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg_s[j] = g_s[j*4+i] | (p_s[j*4+i] & gg_s[j]);
        gp_s[j] = gp_s[j] & p_s[j*4+i];
      end
    end
    gc_s[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c_s[j*4] = gc_s[j];
      for (int i = 1; i < 4; i++) begin
        c_s[j*4+i] = g_s[j*4+i-1] | (p_s[j*4+i-1] & c_s[j*4+i-1]);
      end
    end
    sum_pad_s = p_s ^ c_s;
  end

  assign sum  = sum_pad_s[W-1:0];
  // Padding bits have p=g=0, so the carry out of bit W-1 sits in c_s[W] or gc_s[NG].
  assign cout = (W == WP) ? gc_s[NG] : c_s[W % WP];

endmodule

// File: rtl/mlcla_serial_add64.sv
// Slice-serial adder: one mlcladder slice per cycle, carry chained through
// a register, result held until the consumer takes it.
module mlcla_serial_add64
  import mlcla_serial_add64_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF,
  localparam int TW      = SLICE_W * N_SLICES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] a,
  input  logic [TW-1:0] b,
  input  logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] sum,
  output logic          cout,
  output logic          busy
);

  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  state_t              state_r;
  logic [TW-1:0]       a_r;
  logic [TW-1:0]       b_r;
  logic                carry_r;
  logic [IDX_W-1:0]    idx_r;
  logic [TW-1:0]       sum_r;
  logic                cout_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
  logic [SLICE_W-1:0]  slice_a_s;
  logic [SLICE_W-1:0]  slice_b_s;
  logic [SLICE_W-1:0]  slice_sum_s;
  logic                slice_cout_s;

  assign slice_a_s = a_r[idx_r*SLICE_W +: SLICE_W];
  assign slice_b_s = b_r[idx_r*SLICE_W +: SLICE_W];

  mlcladder #(.W(SLICE_W)) u_add (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Control FSM, operand capture, per-slice result write-back and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= cin;
            idx_r      <= '0;
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_r[idx_r*SLICE_W +: SLICE_W] <= slice_sum_s;
          carry_r                         <= slice_cout_s;
          if (idx_r == LAST_IDX) begin
            cout_r      <= slice_cout_s;
            idx_r       <= '0;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // Retiring edge never accepts a new operand; IDLE must be seen first.
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule
